tcp_tx_rtx_sched: RTL and testbench

- Sequences the TCP transmit control path between the engine and tx_ctl.
- Grants transmission of packets that tx_ctl has formed, and tracks the single oldest unacknowledged packet.
- Runs the retransmission timer and detects duplicate ACKs for fast retransmit.
- Requests connection abort (force_dcn) when retries are exhausted.
- Sits beside tx_ctl in the TCP engine; drives the req/sent/dup_det/force_dcn side of that control path.

---
 rtl/tcp_vlg_pkg.sv | 14 +
 rtl/tcp_rto_timer.sv | 22 ++
 rtl/tcp_tx_rtx_sched.sv | 99 +++++++++
 tb/tb_tcp_tx_rtx_sched.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/tcp_vlg_pkg.sv
// tcp_vlg_pkg: shared types, defaults and modulo-2^32 sequence helpers
// for the TCP engine blocks.
package tcp_vlg_pkg;
   typedef enum logic [2:0] {IDLE, GRANT, WAIT_ACK, RTX, DCN} rtx_state_t;
   localparam int RTO_TICKS_DEF = 1000000;
   localparam int RTO_W_DEF = 20;
   localparam int MAX_RETRIES_DEF = 5;
   localparam int DUP_ACK_THR_DEF = 3;
   function automatic logic seq_ge(input logic [31:0] a, input logic [31:0] b);
      logic [31:0] d;
      d = a - b;
      return ~d[31];
   endfunction
endpackage

// File: rtl/tcp_rto_timer.sv
// tcp_rto_timer: loadable/clearable up-counter whose expiry pulse fires
// while enabled on the count TICKS-1; clear wins over load and increment.
module tcp_rto_timer #(
   parameter int W = 20,
   parameter int TICKS = 1000
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         en,
   output logic         expired
);
   logic [W-1:0] cnt;
   assign expired = en && cnt == W'(TICKS - 1);
   always_ff @(posedge clk) begin
      if (rst || clr) cnt <= '0;
      else if (load) cnt <= load_val;
      else if (en) cnt <= cnt + 1'b1;
   end
endmodule

// File: rtl/tcp_tx_rtx_sched.sv
// tcp_tx_rtx_sched: grants packet transmission, tracks the single oldest
// unacknowledged packet, and drives timeout/fast retransmit and abort.
module tcp_tx_rtx_sched
   import tcp_vlg_pkg::*;
#(
   parameter int RTO_TICKS = RTO_TICKS_DEF,
   parameter int RTO_W = RTO_W_DEF,
   parameter int MAX_RETRIES = MAX_RETRIES_DEF,
   parameter int DUP_ACK_THR = DUP_ACK_THR_DEF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        init,
   input  logic [31:0] init_seq,
   input  logic        send,
   input  logic [31:0] pld_seq,
   input  logic [15:0] pld_len,
   input  logic        sent,
   input  logic        ack_vld,
   input  logic [31:0] ack_num,
   output logic        req,
   output logic        rtx,
   output logic [31:0] rtx_seq,
   output logic [31:0] last_seq,
   output logic        dup_det,
   output logic [31:0] dup_ack,
   output logic        force_dcn
);
   rtx_state_t state;
   logic [31:0] out_seq, out_end;
   logic [7:0] retries, dups;
   logic busy, ack_full, ack_dup, ack_part, dup_hit, tmr_clr, tmr_exp;
   assign busy = state == GRANT || state == WAIT_ACK;
   assign ack_full = seq_ge(ack_num, out_end);
   assign ack_dup = !ack_full && ack_num == last_seq;
   assign ack_part = !ack_full && !ack_dup && seq_ge(ack_num, last_seq);
   assign dup_hit = state == WAIT_ACK && ack_vld && ack_dup && int'(dups) >= DUP_ACK_THR - 1;
   assign tmr_clr = init || (state == GRANT && sent) || (busy && ack_vld && ack_part);
   // sent drops the grant combinationally so the engine never sees a second cycle
   assign req = state == GRANT && !sent;
   tcp_rto_timer #(.W(RTO_W), .TICKS(RTO_TICKS)) u_tmr (
      .clk(clk), .rst(rst), .clr(tmr_clr), .load(1'b0), .load_val('0),
      .en(state == WAIT_ACK), .expired(tmr_exp)
   );
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         {out_seq, out_end, retries, dups} <= '0;
         {rtx, rtx_seq, last_seq, dup_det, dup_ack, force_dcn} <= '0;
      end else if (init) begin
         state <= IDLE;
         last_seq <= init_seq;
         {retries, dups, rtx, dup_det, force_dcn} <= '0;
      end else begin
         dup_det <= 1'b0;
         case (state)
            IDLE: if (send) begin
               out_seq <= pld_seq;
               out_end <= pld_seq + 32'(pld_len);
               state <= GRANT;
            end
            GRANT, WAIT_ACK: begin
               if (state == GRANT && sent) begin
                  rtx <= 1'b0;
                  state <= WAIT_ACK;
               end
               if (ack_vld && ack_full) begin
                  last_seq <= ack_num;
                  {retries, dups, rtx} <= '0;
                  state <= IDLE;
               end else begin
                  if (ack_vld && ack_part) begin
                     last_seq <= ack_num;
                     out_seq <= ack_num;
                     dups <= '0;
                  end
                  if (ack_vld && ack_dup) dups <= dup_hit ? 8'd0 : dups + 8'd1;
                  if (dup_hit) begin
                     dup_det <= 1'b1;
                     dup_ack <= ack_num;
                  end
                  // a partial ack restarts the timer, so it also cancels a same-cycle expiry
                  if (state == WAIT_ACK && (dup_hit || (tmr_exp && !(ack_vld && ack_part)))) state <= RTX;
               end
            end
            RTX: if (int'(retries) == MAX_RETRIES) begin
               force_dcn <= 1'b1;
               state <= DCN;
            end else begin
               retries <= retries + 8'd1;
               rtx <= 1'b1;
               rtx_seq <= out_seq;
               state <= GRANT;
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_tcp_tx_rtx_sched.sv
// tb_tcp_tx_rtx_sched: directed vector table plus hand sequences for
// timeout/abort, fast retransmit, stale acks and the ack/expiry race.
module tb_tcp_tx_rtx_sched;
   logic clk = 0, rst, init, send, sent, ack_vld;
   logic [31:0] init_seq, pld_seq, ack_num;
   logic [15:0] pld_len;
   logic req, rtx, dup_det, force_dcn;
   logic [31:0] rtx_seq, last_seq, dup_ack;
   int errors = 0, checks = 0;

   tcp_tx_rtx_sched #(.RTO_TICKS(50), .RTO_W(20), .MAX_RETRIES(5), .DUP_ACK_THR(3)) dut (
      .clk(clk), .rst(rst), .init(init), .init_seq(init_seq), .send(send),
      .pld_seq(pld_seq), .pld_len(pld_len), .sent(sent), .ack_vld(ack_vld),
      .ack_num(ack_num), .req(req), .rtx(rtx), .rtx_seq(rtx_seq),
      .last_seq(last_seq), .dup_det(dup_det), .dup_ack(dup_ack), .force_dcn(force_dcn)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic rst, init; logic [31:0] iseq;
      logic send; logic [31:0] pseq; logic [15:0] plen;
      logic sent, av; logic [31:0] an;
      logic req, rtx; logic [31:0] rseq, last;
      logic dd; logic [31:0] dack; logic fd;
   } vec_t;
   vec_t vec[23];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic slot();
      @(negedge clk);
      rst = 0; init = 0; send = 0; sent = 0; ack_vld = 0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int k;
      logic seen;
      init_seq = 0; pld_seq = 0; pld_len = 0; ack_num = 0;
      //              rst init iseq           snd pseq           plen  snt av an            req rtx rseq    last           dd dack    fd
      vec[0]  = '{0, 0, 0,             0, 0,             0,    0, 0, 0,             0, 0, 0,      0,             0, 0,      0};
      vec[1]  = '{0, 1, 1000,          0, 0,             0,    0, 0, 0,             0, 0, 0,      0,             0, 0,      0};
      vec[2]  = '{0, 0, 0,             1, 1000,          100,  0, 0, 0,             0, 0, 0,      1000,          0, 0,      0};
      vec[3]  = '{0, 0, 0,             0, 0,             0,    0, 0, 0,             1, 0, 0,      1000,          0, 0,      0};
      vec[4]  = '{0, 0, 0,             0, 0,             0,    1, 0, 0,             0, 0, 0,      1000,          0, 0,      0};
      vec[5]  = '{0, 0, 0,             0, 0,             0,    0, 1, 900,           0, 0, 0,      1000,          0, 0,      0};
      vec[6]  = '{0, 0, 0,             0, 0,             0,    0, 1, 1100,          0, 0, 0,      1000,          0, 0,      0};
      vec[7]  = '{0, 0, 0,             0, 0,             0,    0, 0, 0,             0, 0, 0,      1100,          0, 0,      0};
      vec[8]  = '{0, 1, 32'hFFFF_FFC0, 0, 0,             0,    0, 0, 0,             0, 0, 0,      1100,          0, 0,      0};
      vec[9]  = '{0, 0, 0,             1, 32'hFFFF_FFC0, 128,  0, 0, 0,             0, 0, 0,      32'hFFFF_FFC0, 0, 0,      0};
      vec[10] = '{0, 0, 0,             0, 0,             0,    1, 0, 0,             0, 0, 0,      32'hFFFF_FFC0, 0, 0,      0};
      vec[11] = '{0, 0, 0,             0, 0,             0,    0, 1, 32'h10,        0, 0, 0,      32'hFFFF_FFC0, 0, 0,      0};
      vec[12] = '{0, 0, 0,             0, 0,             0,    0, 1, 32'h10,        0, 0, 0,      32'h10,        0, 0,      0};
      vec[13] = '{0, 0, 0,             0, 0,             0,    0, 1, 32'h10,        0, 0, 0,      32'h10,        0, 0,      0};
      vec[14] = '{0, 0, 0,             0, 0,             0,    0, 1, 32'h10,        0, 0, 0,      32'h10,        0, 0,      0};
      vec[15] = '{0, 0, 0,             0, 0,             0,    0, 0, 0,             0, 0, 0,      32'h10,        1, 32'h10, 0};
      vec[16] = '{0, 0, 0,             0, 0,             0,    0, 0, 0,             1, 1, 32'h10, 32'h10,        0, 32'h10, 0};
      vec[17] = '{0, 0, 0,             0, 0,             0,    0, 1, 32'h40,        1, 1, 32'h10, 32'h10,        0, 32'h10, 0};
      vec[18] = '{0, 0, 0,             0, 0,             0,    0, 0, 0,             0, 0, 32'h10, 32'h40,        0, 32'h10, 0};
      vec[19] = '{0, 0, 0,             1, 32'h40,        10,   0, 0, 0,             0, 0, 32'h10, 32'h40,        0, 32'h10, 0};
      vec[20] = '{0, 0, 0,             0, 0,             0,    0, 0, 0,             1, 0, 32'h10, 32'h40,        0, 32'h10, 0};
      vec[21] = '{1, 0, 0,             0, 0,             0,    0, 0, 0,             1, 0, 32'h10, 32'h40,        0, 32'h10, 0};
      vec[22] = '{0, 0, 0,             0, 0,             0,    0, 0, 0,             0, 0, 0,      0,             0, 0,      0};

      slot(); rst = 1;
      slot(); rst = 1;
      for (int i = 0; i < 23; i++) begin
         slot();
         rst = vec[i].rst; init = vec[i].init; init_seq = vec[i].iseq;
         send = vec[i].send; pld_seq = vec[i].pseq; pld_len = vec[i].plen;
         sent = vec[i].sent; ack_vld = vec[i].av; ack_num = vec[i].an;
         #1;
         chk($sformatf("v%0d req", i), 32'(req), 32'(vec[i].req));
         chk($sformatf("v%0d rtx", i), 32'(rtx), 32'(vec[i].rtx));
         chk($sformatf("v%0d rtx_seq", i), rtx_seq, vec[i].rseq);
         chk($sformatf("v%0d last_seq", i), last_seq, vec[i].last);
         chk($sformatf("v%0d dup_det", i), 32'(dup_det), 32'(vec[i].dd));
         chk($sformatf("v%0d dup_ack", i), dup_ack, vec[i].dack);
         chk($sformatf("v%0d force_dcn", i), 32'(force_dcn), 32'(vec[i].fd));
      end

      // timeout: five retransmissions, then the sixth expiry aborts
      slot(); init = 1; init_seq = 1000;
      slot(); send = 1; pld_seq = 1000; pld_len = 100;
      slot(); #1; chk("to_first_req", 32'(req), 1);
      sent = 1;
      for (int r = 0; r < 6; r++) begin
         k = 0;
         do begin slot(); #1; k++; end while (!req && !force_dcn && k < 60);
         chk($sformatf("to%0d latency", r), k, 52);
         if (r < 5) begin
            chk($sformatf("to%0d req", r), 32'(req), 1);
            chk($sformatf("to%0d rtx", r), 32'(rtx), 1);
            chk($sformatf("to%0d rtx_seq", r), rtx_seq, 1000);
            chk($sformatf("to%0d force_dcn", r), 32'(force_dcn), 0);
            sent = 1;
         end else begin
            chk("to_dcn force_dcn", 32'(force_dcn), 1);
            chk("to_dcn req", 32'(req), 0);
         end
      end
      slot(); send = 1; #1; chk("dcn send_ignored", 32'(req), 0);
      slot(); #1; chk("dcn req_stays0", 32'(req), 0);
      chk("dcn sticky", 32'(force_dcn), 1);
      slot(); init = 1; init_seq = 1000;
      slot(); #1; chk("init clears force_dcn", 32'(force_dcn), 0);

      // full ack on the same cycle the timer expires: ack wins
      slot(); send = 1; pld_seq = 1000; pld_len = 100;
      slot(); #1; chk("race req", 32'(req), 1);
      sent = 1;
      for (int j = 1; j <= 50; j++) begin
         slot();
         if (j == 50) begin ack_vld = 1; ack_num = 1100; end
      end
      seen = 0;
      for (int j = 0; j < 5; j++) begin slot(); #1; seen |= req | rtx; end
      chk("race no_rtx", 32'(seen), 0);
      chk("race last_seq", last_seq, 1100);

      // stale acks do not count as duplicates; three real dups fast-retransmit
      slot(); init = 1; init_seq = 1000;
      slot(); send = 1; pld_seq = 1000; pld_len = 100;
      slot(); #1; chk("fr req", 32'(req), 1);
      sent = 1;
      seen = 0;
      for (int j = 0; j < 3; j++) begin slot(); ack_vld = 1; ack_num = 900; #1; seen |= dup_det; end
      for (int j = 0; j < 2; j++) begin slot(); ack_vld = 1; ack_num = 1000; #1; seen |= dup_det; end
      slot(); #1; seen |= dup_det | req;
      chk("stale no_dup", 32'(seen), 0);
      chk("stale last_seq", last_seq, 1000);
      slot(); ack_vld = 1; ack_num = 1000;
      slot(); #1;
      chk("fr dup_det", 32'(dup_det), 1);
      chk("fr dup_ack", dup_ack, 1000);
      chk("fr req_in_rtx", 32'(req), 0);
      slot(); #1;
      chk("fr dup_det_pulse", 32'(dup_det), 0);
      chk("fr rtx_req", 32'(req), 1);
      chk("fr rtx", 32'(rtx), 1);
      chk("fr rtx_seq", rtx_seq, 1000);
      sent = 1; #1;
      chk("fr sent_drops_req", 32'(req), 0);
      slot(); #1; chk("fr rtx_cleared", 32'(rtx), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
